// File: rtl/vga_pmod_out.sv
// VGA timing generator and TinyVGA-Pmod output stage: h/v counters, a delay line that keeps
// sync aligned with the pattern generator's pixels, and optional 2x2 Bayer dither to 2 bits/channel.
module vga_pmod_out #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SYNC_POL    = 0,
   parameter int COLOR_BITS  = 4,
   parameter int DITHER      = 1,
   parameter int PIX_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   output logic [9:0]                x,
   output logic [9:0]                y,
   output logic                      active,
   output logic                      frame_start,
   output logic [7:0]                frame_cnt,
   input  logic [3*COLOR_BITS-1:0]   pix_rgb,
   output logic [7:0]                uo_out
);

   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic       SP       = 1'(SYNC_POL);
   localparam int         CB       = COLOR_BITS;

   logic       hsync_raw;
   logic       vsync_raw;
   logic [4:0] tap_in;
   logic [4:0] tap_out;
   logic       d_active;
   logic       d_hsync;
   logic       d_vsync;
   logic       d_x0;
   logic       d_y0;
   logic [1:0] bayer_t;
   logic [1:0] r2;
   logic [1:0] g2;
   logic [1:0] b2;
   logic [7:0] uo_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         frame_cnt <= '0;
      end else if (en) begin
         if (x == H_LAST) begin
            x <= '0;
            if (y == V_LAST) begin
               y         <= '0;
               frame_cnt <= frame_cnt + 8'd1;
            end else begin
               y <= y + 10'd1;
            end
         end else begin
            x <= x + 10'd1;
         end
      end
   end

   assign active      = (x < H_VIS) && (y < V_VIS);
   assign frame_start = en && !rst && (x == '0) && (y == '0);
   assign hsync_raw   = (x >= HS_START) && (x < HS_END);
   assign vsync_raw   = (y >= VS_START) && (y < VS_END);
   assign tap_in      = {active, hsync_raw, vsync_raw, x[0], y[0]};

   // Newest tap enters at the LSB end; the cast drops the oldest entry off the top.
   generate
      if (PIX_LATENCY == 0) begin : g_no_dly
         assign tap_out = tap_in;
      end else begin : g_dly
         logic [5*PIX_LATENCY-1:0] dly;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)     dly <= '0;
            else if (en) dly <= (5*PIX_LATENCY)'({dly, tap_in});
         end
         assign tap_out = dly[5*PIX_LATENCY-1 -: 5];
      end
   endgenerate

   assign {d_active, d_hsync, d_vsync, d_x0, d_y0} = tap_out;

   // Low two bits are zero padding so f exists even when COLOR_BITS < 4.
   function automatic logic [1:0] reduce_chan(input logic [CB-1:0] v, input logic [1:0] t);
      logic [CB+1:0] p;
      logic [1:0]    q;
      logic [1:0]    f;
      p = {v, 2'b00};
      q = p[CB+1 -: 2];
      f = p[CB-1 -: 2];
      if ((DITHER != 0) && (f > t) && (q != 2'd3)) return q + 2'd1;
      return q;
   endfunction

   always_comb begin
      bayer_t = 2'd0;
      unique case ({d_y0, d_x0})
         2'b00:   bayer_t = 2'd0;
         2'b01:   bayer_t = 2'd2;
         2'b10:   bayer_t = 2'd3;
         default: bayer_t = 2'd1;
      endcase
      r2 = reduce_chan(pix_rgb[3*CB-1 -: CB], bayer_t);
      g2 = reduce_chan(pix_rgb[2*CB-1 -: CB], bayer_t);
      b2 = reduce_chan(pix_rgb[CB-1:0], bayer_t);
      if (!d_active) begin
         r2 = '0;
         g2 = '0;
         b2 = '0;
      end
      uo_next = {d_hsync ? SP : ~SP, b2[0], g2[0], r2[0],
                 d_vsync ? SP : ~SP, b2[1], g2[1], r2[1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     uo_out <= {~SP, 3'b000, ~SP, 3'b000};
      else if (en) uo_out <= uo_next;
   end

endmodule

// File: tb/tb_vga_pmod_out.sv
// Scoreboard bench for vga_pmod_out on a small 25x10 raster with PIX_LATENCY=2 and active-high sync.
module tb_vga_pmod_out;

   localparam int HT = 25;
   localparam int VT = 10;
   localparam int L  = 2;
   localparam logic [7:0] IDLE = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        active;
   logic        frame_start;
   logic [7:0]  frame_cnt;
   logic [11:0] pix_rgb;
   logic [7:0]  uo_out;

   int          mx;
   int          my;
   logic [7:0]  mfc;
   logic [7:0]  reg_exp;
   logic [7:0]  pipe[$];
   logic [11:0] hist[$];
   int          mode;
   int          fs_model;
   int          fs_seen;
   int          vectors;
   int          miscompares;

   vga_pmod_out #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1), .COLOR_BITS(4), .DITHER(1), .PIX_LATENCY(L)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .active(active),
      .frame_start(frame_start), .frame_cnt(frame_cnt), .pix_rgb(pix_rgb), .uo_out(uo_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_start) fs_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [11:0] pattern(int xi, int yi);
      logic [31:0] h;
      case (mode)
         0:       h = 32'hFFF;
         1:       h = 32'h6F9;
         default: h = 32'(xi * 37) ^ 32'(yi * 101) ^ 32'(xi << 5);
      endcase
      return h[11:0];
   endfunction

   function automatic logic [7:0] exp_uo(int xi, int yi, logic [11:0] rgb);
      bit         act;
      int         idx;
      int         t;
      int         v;
      int         q;
      int         f;
      int         o[3];
      logic [7:0] u;
      act = (xi < 16) && (yi < 6);
      idx = (yi % 2) * 2 + (xi % 2);
      t   = (idx == 0) ? 0 : (idx == 1) ? 2 : (idx == 2) ? 3 : 1;
      for (int c = 0; c < 3; c++) begin
         v = (int'(rgb) >> (8 - 4 * c)) & 15;
         q = v >> 2;
         f = v & 3;
         o[c] = (f > t && q != 3) ? q + 1 : q;
         if (!act) o[c] = 0;
      end
      u[7] = (xi >= 18 && xi < 22);
      u[6] = o[2][0];
      u[5] = o[1][0];
      u[4] = o[0][0];
      u[3] = (yi >= 7 && yi < 9);
      u[2] = o[2][1];
      u[1] = o[1][1];
      u[0] = o[0][1];
      return u;
   endfunction

   task automatic model_reset();
      mx  = 0;
      my  = 0;
      mfc = '0;
      pipe.delete();
      hist.delete();
      for (int i = 0; i < L; i++) pipe.push_back(IDLE);
      reg_exp = IDLE;
      pix_rgb = '0;
   endtask

   task automatic step(input logic en_v);
      logic [11:0] rgb;
      bit          fs_exp;
      @(negedge clk);
      check("x", x, mx);
      check("y", y, my);
      check("frame_cnt", frame_cnt, mfc);
      check("uo_out", uo_out, reg_exp);
      en = en_v;
      #1;
      fs_exp = en_v && mx == 0 && my == 0;
      check("frame_start", frame_start, fs_exp);
      check("active", active, (mx < 16 && my < 6));
      if (en_v) begin
         rgb = pattern(mx, my);
         hist.push_back(rgb);
         if (hist.size() > L + 1) void'(hist.pop_front());
         pix_rgb = (hist.size() == L + 1) ? hist[0] : 12'h000;
         pipe.push_back(exp_uo(mx, my, rgb));
         if (pipe.size() > L) reg_exp = pipe.pop_front();
         if (fs_exp) fs_model++;
         mx++;
         if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) begin
               my  = 0;
               mfc = mfc + 8'd1;
            end
         end
      end
   endtask

   initial begin
      bit seen255;
      vectors     = 0;
      miscompares = 0;
      fs_model    = 0;
      fs_seen     = 0;
      mode        = 0;
      rst         = 1'b1;
      en          = 1'b0;
      pix_rgb     = '0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      #1;
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_fc", frame_cnt, 0);
      check("rst_uo", uo_out, IDLE);
      check("rst_fs", frame_start, 0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Full-white frames, then a fixed colour that exercises dither and saturation.
      for (int i = 0; i < 2 * HT * VT; i++) step(1'b1);
      mode = 1;
      for (int i = 0; i < HT * VT; i++) step(1'b1);

      // Stall for 7 clocks mid-line.
      mode = 2;
      for (int i = 0; i < HT && mx != 10; i++) step(1'b1);
      check("stall_at", mx, 10);
      repeat (7) step(1'b0);
      for (int i = 0; i < 100; i++) step(1'b1);

      for (int i = 0; i < 1000; i++) step($urandom_range(0, 3) != 0);

      // Run until frame_cnt wraps 255 -> 0.
      seen255 = 0;
      for (int i = 0; i < 70000; i++) begin
         step(1'b1);
         if (mfc == 8'd255) seen255 = 1;
         if (seen255 && mfc == 8'd0) break;
      end
      step(1'b0);
      check("fc_wrap", frame_cnt, 8'd0);

      // Asynchronous reset mid-frame while pixels are lit.
      mode = 0;
      for (int i = 0; i < HT * VT && !(mx == 10 && my == 3); i++) step(1'b1);
      check("rst_pt_nonidle", (uo_out != IDLE), 1);
      rst = 1'b1;
      #1;
      check("arst_uo", uo_out, 8'h00);
      check("arst_x", x, 0);
      check("arst_y", y, 0);
      check("arst_fc", frame_cnt, 0);
      check("arst_fs", frame_start, 0);
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 300; i++) step(1'b1);
      step(1'b0);

      check("fs_count", fs_seen, fs_model);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
